usb_reg_master: RTL and testbench
=================================

USB_REG_MASTER -- requirements
Module: usb_reg_master

Interface
REQ-001 SHALL have parameter pBYTECNT_SIZE, default 7, burst-length field width; maximum burst is 2^pBYTECNT_SIZE-1 bytes.
REQ-002 SHALL have parameter pSETUP_CYCLES, default 1, CEn-low cycles before each strobe.
REQ-003 SHALL have parameter pSTROBE_CYCLES, default 2, WRn/RDn low width.
REQ-004 SHALL have parameter pHOLD_CYCLES, default 1, cycles after strobe release before next byte.
REQ-005 SHALL have parameter pTIMEOUT, default 255, write-data stall limit in cycles.
REQ-006 SHALL have ports, one per line:
- clk_usb  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  8  register address.
- cmd_len  in  pBYTECNT_SIZE  byte count.
- wr_data/wr_valid/wr_ready  in/in/out  8/1/1  write byte stream.
- rd_data/rd_valid  out  8/1  read byte, one-cycle valid.
- done/err  out  1/1  one-cycle completion and abort flags.
- busy  out  1  high outside IDLE.
- USB_Addr  out  8  bus address.
- USB_Data_o/USB_Data_oe/USB_Data_i  out/out/in  8/1/8  split bidirectional data; tristate lives in the wrapper.
- USB_ALEn/USB_CEn/USB_WRn/USB_RDn  out  1 each  active-low bus strobes.

Function
REQ-007 SHALL implement FSM IDLE, ALE, LOAD, SETUP, STROBE, HOLD, DONE.
REQ-008 cmd_ready SHALL be high only in IDLE; command fields SHALL be captured on cmd_valid&&cmd_ready.
REQ-009 cmd_len=0 SHALL go IDLE->DONE with no bus activity, done=1, err=0.
REQ-010 ALE SHALL last one cycle with USB_ALEn=0 and USB_Addr=captured address; USB_Addr SHALL hold that value until IDLE.
REQ-011 Writes SHALL enter LOAD per byte: wr_ready=1, stay until wr_valid, capture wr_data into the data register, then SETUP; reads SHALL skip LOAD.
REQ-012 USB_CEn SHALL be 0 in LOAD, SETUP, STROBE, HOLD and 1 elsewhere.
REQ-013 USB_Data_oe SHALL be 1 only in SETUP, STROBE, HOLD of write bursts; USB_Data_o SHALL come from the data register.
REQ-014 STROBE SHALL drive USB_WRn=0 (write) or USB_RDn=0 (read) for exactly pSTROBE_CYCLES; the other strobe SHALL stay 1.
REQ-015 Reads SHALL sample USB_Data_i on the last STROBE cycle and present it on rd_data with rd_valid=1 the following cycle.
REQ-016 HOLD SHALL go to the next byte (LOAD or SETUP) if bytes remain, else to DONE; DONE SHALL last one cycle with done=1, then IDLE.
REQ-017 The byte counter SHALL decrement at each HOLD exit and SHALL not wrap.
REQ-018 A new command SHALL not be accepted before DONE completes; cmd_valid during busy SHALL be ignored.

Reset
REQ-019 reset_n=0 SHALL immediately force IDLE, all strobes=1, USB_Data_oe=0, cmd_ready=0, wr_ready=0, rd_valid=0, done=0, err=0, busy=0, USB_Addr=0, USB_Data_o=0.
REQ-020 Reset mid-strobe SHALL release the strobe asynchronously; no done or err SHALL follow; cmd_ready SHALL rise the first cycle after release.

Configuration
REQ-021 With USB_REG_MASTER_TIMEOUT_EN defined, pTIMEOUT consecutive LOAD cycles without wr_valid SHALL abort to DONE with done=1 and err=1; bytes already strobed are not retracted.
REQ-022 Without USB_REG_MASTER_TIMEOUT_EN, LOAD SHALL wait indefinitely and err SHALL be constant 0.

Structure
REQ-023 Package usb_reg_master_pkg SHALL hold the state enum and default timing constants.
REQ-024 A sub-module usb_strobe_timer (loadable down-counter with terminal-count flag) SHALL time SETUP, STROBE, HOLD and the timeout.

Verification
REQ-025 Write, addr=0x10, len=1, data 0xA5 ready at T+2 (accept at T) -> ALEn=0 at T+1; LOAD T+2; WRn=0 T+4..T+5 with data 0xA5; done at T+7; cmd_ready at T+8.
REQ-026 Read, addr=0x22, len=2, slave returns 0x3C then 0xC3 -> two 2-cycle RDn pulses; rd_valid with 0x3C then 0xC3; done once; USB_Data_oe stays 0.
REQ-027 Write len=3 with wr_valid withheld 10 cycles before byte 2 -> CEn stays 0; no WRn pulse during the stall; three WRn pulses total; err=0.
REQ-028 len=0 -> done one cycle after accept; ALEn, CEn, WRn, RDn never low.
REQ-029 reset_n low during the second STROBE cycle -> WRn=1 and USB_Data_oe=0 in the same cycle; no done; a new command is accepted after release.
REQ-030 With USB_REG_MASTER_TIMEOUT_EN and pTIMEOUT=8, wr_valid never high -> done=1, err=1 after 8 LOAD cycles; zero WRn pulses.

Source files
------------

// File: rtl/usb_reg_master_pkg.sv
// usb_reg_master_pkg: FSM state encoding and default bus timing for the USB register master.
package usb_reg_master_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ALE, S_LOAD, S_SETUP, S_STROBE, S_HOLD, S_DONE
  } state_t;
  localparam int DEF_BYTECNT_SIZE  = 7;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_TIMEOUT       = 255;
  localparam int TIMER_W           = 16;
endpackage

// File: rtl/usb_strobe_timer.sv
// usb_strobe_timer: loadable down-counter; tc is high while the count sits at zero.
module usb_strobe_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = (cnt == '0);
endmodule

// File: rtl/usb_reg_master.sv
// usb_reg_master: burst register master driving an ALE-multiplexed 8-bit USB FIFO-chip bus.
// Optional write-data stall abort: define USB_REG_MASTER_TIMEOUT_EN.
module usb_reg_master
  import usb_reg_master_pkg::*;
#(
  parameter int pBYTECNT_SIZE  = DEF_BYTECNT_SIZE,
  parameter int pSETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int pSTROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int pHOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int pTIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [7:0]               cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  output logic [7:0]               USB_Addr,
  output logic [7:0]               USB_Data_o,
  output logic                     USB_Data_oe,
  input  logic [7:0]               USB_Data_i,
  output logic                     USB_ALEn,
  output logic                     USB_CEn,
  output logic                     USB_WRn,
  output logic                     USB_RDn
);
  state_t state, next;
  logic write;
  logic [pBYTECNT_SIZE-1:0] cnt;
  logic [7:0] data;
  logic tc, load, timeout, last_strobe;
  logic [TIMER_W-1:0] tval;

`ifdef USB_REG_MASTER_TIMEOUT_EN
  assign timeout = tc;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_usb or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = !cmd_valid ? S_IDLE : (cmd_len == '0) ? S_DONE : S_ALE;
      S_ALE:    next = write ? S_LOAD : S_SETUP;
      S_LOAD:   next = wr_valid ? S_SETUP : timeout ? S_DONE : S_LOAD;
      S_SETUP:  next = tc ? S_STROBE : S_SETUP;
      S_STROBE: next = tc ? S_HOLD : S_STROBE;
      S_HOLD:   next = !tc ? S_HOLD : (cnt > pBYTECNT_SIZE'(1)) ? (write ? S_LOAD : S_SETUP) : S_DONE;
      default:  next = S_IDLE;
    endcase
  end

  // The timer reloads on every state change with the duration of the state being entered.
  assign load = (next != state);
  assign tval = (next == S_LOAD)   ? TIMER_W'(pTIMEOUT - 1) :
                (next == S_SETUP)  ? TIMER_W'(pSETUP_CYCLES - 1) :
                (next == S_STROBE) ? TIMER_W'(pSTROBE_CYCLES - 1) :
                                     TIMER_W'(pHOLD_CYCLES - 1);

  usb_strobe_timer #(.W(TIMER_W)) u_timer (
    .clk(clk_usb), .reset_n(reset_n), .load(load), .value(tval), .tc(tc)
  );

  assign last_strobe = (state == S_STROBE) && tc;

  always_ff @(posedge clk_usb or negedge reset_n)
    if (!reset_n) begin
      USB_Addr <= '0;
      write    <= 1'b0;
      cnt      <= '0;
      data     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        USB_Addr <= cmd_addr;
        write    <= cmd_write;
        cnt      <= cmd_len;
      end
      if (state == S_LOAD && wr_valid) data <= wr_data;
      if (state == S_HOLD && tc && cnt != '0) cnt <= cnt - pBYTECNT_SIZE'(1);
      rd_valid <= last_strobe && !write;
      if (last_strobe && !write) rd_data <= USB_Data_i;
    end

`ifdef USB_REG_MASTER_TIMEOUT_EN
  logic abort;
  always_ff @(posedge clk_usb or negedge reset_n)
    if (!reset_n) abort <= 1'b0;
    else abort <= (state == S_LOAD && !wr_valid && tc) || (abort && state != S_IDLE);
  assign err = (state == S_DONE) && abort;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready   = reset_n && (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign wr_ready    = (state == S_LOAD);
  assign USB_ALEn    = (state != S_ALE);
  assign USB_CEn     = !(state inside {S_LOAD, S_SETUP, S_STROBE, S_HOLD});
  assign USB_WRn     = !(state == S_STROBE && write);
  assign USB_RDn     = !(state == S_STROBE && !write);
  assign USB_Data_oe = write && (state inside {S_SETUP, S_STROBE, S_HOLD});
  assign USB_Data_o  = data;
endmodule

// File: tb/tb_usb_reg_master.sv
// tb_usb_reg_master: scoreboard bench for usb_reg_master with a bus-slave model and write-stream driver.
module tb_usb_reg_master;
  logic clk_usb = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0;
  logic [6:0] cmd_len = 0;
  logic [7:0] wr_data, rd_data, USB_Addr, USB_Data_o, USB_Data_i = 0;
  logic wr_valid, wr_ready, rd_valid, done, err, busy, USB_Data_oe;
  logic USB_ALEn, USB_CEn, USB_WRn, USB_RDn;

  usb_reg_master #(.pTIMEOUT(8)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .busy(busy), .USB_Addr(USB_Addr), .USB_Data_o(USB_Data_o),
    .USB_Data_oe(USB_Data_oe), .USB_Data_i(USB_Data_i), .USB_ALEn(USB_ALEn),
    .USB_CEn(USB_CEn), .USB_WRn(USB_WRn), .USB_RDn(USB_RDn)
  );

  always #5 clk_usb = ~clk_usb;
  int cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] exp_wr[$], exp_rd[$], slave_q[$], wd_q[$];
  int ws_q[$], wr_fall[$];
  logic [7:0] exp_addr = 0;
  int wr_pulses = 0, rd_pulses = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0, ale_cyc = 0;
  int act_cnt = 0, oe_cnt = 0, cen_gaps = 0, wr_low = 0, rd_low = 0;
  logic pwr = 1, prd = 1;

  // Bus monitor and slave: all observation happens on the falling edge.
  always @(negedge clk_usb) begin
    if (!reset_n) begin
      pwr = 1; prd = 1;
    end else begin
      if (!USB_WRn && pwr) begin
        wr_pulses++; wr_fall.push_back(cyc); wr_low = 0;
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) check("wr_data", USB_Data_o, exp_wr.pop_front());
        check("wr_oe", USB_Data_oe, 1);
        check("wr_rdn", USB_RDn, 1);
        check("wr_addr", USB_Addr, exp_addr);
      end
      if (!USB_WRn) wr_low++;
      if (USB_WRn && !pwr) check("wr_width", wr_low, 2);
      if (!USB_RDn && prd) begin
        rd_pulses++; rd_low = 0;
        USB_Data_i = slave_q.size() > 0 ? slave_q.pop_front() : 8'hEE;
        check("rd_oe", USB_Data_oe, 0);
        check("rd_wrn", USB_WRn, 1);
      end
      if (!USB_RDn) rd_low++;
      if (USB_RDn && !prd) check("rd_width", rd_low, 2);
      if (rd_valid) begin
        check("rd_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin done_cnt++; done_cyc = cyc; if (err) err_cnt++; end
      if (!USB_ALEn) begin ale_cyc = cyc; check("ale_addr", USB_Addr, exp_addr); end
      if (!USB_ALEn || !USB_CEn || !USB_WRn || !USB_RDn) act_cnt++;
      if (USB_Data_oe) oe_cnt++;
      if (busy && USB_CEn && USB_ALEn && !done) cen_gaps++;
      pwr = USB_WRn; prd = USB_RDn;
    end
  end

  // Write-stream source: each byte waits its stall count of LOAD cycles before wr_valid.
  initial begin
    wr_valid = 0; wr_data = 0;
    forever begin
      @(negedge clk_usb);
      wr_valid = 0;
      if (reset_n && wr_ready && wd_q.size() > 0) begin
        if (ws_q[0] > 0) ws_q[0] = ws_q[0] - 1;
        else begin
          wr_valid = 1; wr_data = wd_q.pop_front(); void'(ws_q.pop_front());
        end
      end
    end
  end

  task automatic push_wr(input logic [7:0] d, input int stall);
    exp_wr.push_back(d); wd_q.push_back(d); ws_q.push_back(stall);
  endtask

  task automatic push_rd(input logic [7:0] d);
    slave_q.push_back(d); exp_rd.push_back(d);
  endtask

  task automatic run_cmd(input logic w, input logic [7:0] a, input logic [6:0] n, output int t);
    int k = 0;
    @(negedge clk_usb); #1;
    cmd_write = w; cmd_addr = a; cmd_len = n; cmd_valid = 1; exp_addr = a;
    while (!cmd_ready && k < 100) begin @(negedge clk_usb); #1; k++; end
    check("cmd_accept_to", cmd_ready, 1);
    t = cyc;
    @(posedge clk_usb); #1 cmd_valid = 0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 200) begin @(negedge clk_usb); #1; k++; end
    check("done_to", done_cnt, d0 + 1);
  endtask

  initial begin
    int t, d0, w0, r0, a0, o0, e0, k;
    #12;
    check("rst_strobes", {USB_ALEn, USB_CEn, USB_WRn, USB_RDn}, 4'hF);
    check("rst_flags", {USB_Data_oe, cmd_ready, wr_ready, rd_valid, done, err, busy}, 0);
    check("rst_addr", USB_Addr, 0);
    check("rst_data_o", USB_Data_o, 0);
    @(negedge clk_usb); reset_n = 1;

    // Single-byte write: exact cycle positions
    d0 = done_cnt; e0 = err_cnt;
    push_wr(8'hA5, 0);
    run_cmd(1, 8'h10, 1, t);
    wait_done(d0);
    check("w1_ale_cyc", ale_cyc, t + 1);
    check("w1_wr_cyc", wr_fall[$], t + 4);
    check("w1_done_cyc", done_cyc, t + 7);
    check("w1_ready_in_done", cmd_ready, 0);
    while (cyc < t + 8) @(negedge clk_usb);
    #1 check("w1_ready_t8", cmd_ready, 1);
    check("w1_err", err_cnt, e0);

    // Two-byte read
    d0 = done_cnt; r0 = rd_pulses; o0 = oe_cnt;
    push_rd(8'h3C); push_rd(8'hC3);
    run_cmd(0, 8'h22, 2, t);
    wait_done(d0);
    repeat (3) @(negedge clk_usb);
    #1 check("r2_pulses", rd_pulses - r0, 2);
    check("r2_done_once", done_cnt, d0 + 1);
    check("r2_oe", oe_cnt - o0, 0);
    check("r2_rd_left", exp_rd.size(), 0);

    // Three-byte write with a 10-cycle stall before byte 2
    d0 = done_cnt; w0 = wr_pulses; e0 = err_cnt; cen_gaps = 0;
    push_wr(8'h11, 0); push_wr(8'h22, 10); push_wr(8'h33, 0);
    run_cmd(1, 8'h31, 3, t);
    wait_done(d0);
    check("w3_pulses", wr_pulses - w0, 3);
    check("w3_gap_stall", wr_fall[w0 + 1] - wr_fall[w0], 15);
    check("w3_gap_nostall", wr_fall[w0 + 2] - wr_fall[w0 + 1], 5);
    check("w3_cen_gaps", cen_gaps, 0);
    check("w3_err", err_cnt, e0);

    // Zero-length command
    d0 = done_cnt; a0 = act_cnt;
    run_cmd(1, 8'h44, 0, t);
    wait_done(d0);
    check("z_done_cyc", done_cyc, t + 1);
    check("z_activity", act_cnt - a0, 0);

    // Random write and read bursts
    d0 = done_cnt; w0 = wr_pulses;
    for (int i = 0; i < 4; i++) push_wr(8'($urandom_range(0, 255)), $urandom_range(0, 3));
    run_cmd(1, 8'($urandom_range(0, 255)), 4, t);
    wait_done(d0);
    check("rw_pulses", wr_pulses - w0, 4);
    d0 = done_cnt; r0 = rd_pulses;
    for (int i = 0; i < 3; i++) push_rd(8'($urandom_range(0, 255)));
    run_cmd(0, 8'($urandom_range(0, 255)), 3, t);
    wait_done(d0);
    repeat (2) @(negedge clk_usb);
    check("rr_pulses", rd_pulses - r0, 3);
    check("rr_left", exp_rd.size(), 0);

    // Reset during the second strobe cycle
    d0 = done_cnt;
    push_wr(8'h5A, 0);
    run_cmd(1, 8'h40, 1, t);
    k = 0;
    while (USB_WRn && k < 50) begin @(negedge clk_usb); k++; end
    check("rs_wr_seen", USB_WRn, 0);
    @(posedge clk_usb); #2 reset_n = 0;
    #1;
    check("rs_wrn", USB_WRn, 1);
    check("rs_oe", USB_Data_oe, 0);
    check("rs_busy_ready", {busy, cmd_ready}, 0);
    repeat (3) @(negedge clk_usb);
    reset_n = 1;
    #1 check("rs_ready", cmd_ready, 1);
    repeat (4) @(negedge clk_usb);
    check("rs_no_done", done_cnt, d0);
    d0 = done_cnt;
    push_rd(8'h77);
    run_cmd(0, 8'h41, 1, t);
    wait_done(d0);
    repeat (2) @(negedge clk_usb);
    check("rs_rd_left", exp_rd.size(), 0);

`ifdef USB_REG_MASTER_TIMEOUT_EN
    // Write with no data ever offered
    d0 = done_cnt; w0 = wr_pulses; e0 = err_cnt;
    run_cmd(1, 8'h50, 1, t);
    wait_done(d0);
    check("to_done_cyc", done_cyc, t + 10);
    check("to_err", err_cnt, e0 + 1);
    check("to_pulses", wr_pulses - w0, 0);
`endif

    check("wr_left", exp_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
